// File: rtl/muxn_rr.sv
// N-input valid/ready stream multiplexer with round-robin or fixed-priority
// arbitration and a single registered output stage.
module muxn_rr #(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int RR    = 1,
   parameter int SRCW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] d,
   input  logic [N-1:0]       d_valid,
   output logic [N-1:0]       d_ready,
   output logic [WIDTH-1:0]   y,
   output logic [SRCW-1:0]    y_src,
   output logic               y_valid,
   input  logic               y_ready
);

   logic [N-1:0][WIDTH-1:0] d_ch;
   logic [N-1:0]            hi_mask;
   logic [N-1:0]            req_hi;
   logic [N-1:0]            gnt_hi;
   logic [N-1:0]            gnt_lo;
   logic [N-1:0]            gnt;
   logic [SRCW-1:0]         gnt_idx;
   logic [WIDTH-1:0]        gnt_data;
   logic                    open;
   logic                    load;

   logic [WIDTH-1:0] y_q, y_d;
   logic [SRCW-1:0]  y_src_q, y_src_d;
   logic             y_valid_q, y_valid_d;
   logic [SRCW-1:0]  ptr_q, ptr_d;

   assign d_ch = d;

   // Round-robin: requesters above ptr win first, otherwise wrap to the lowest.
   // With RR=0 the mask is empty, which degenerates to plain lowest-index priority.
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_mask
         assign hi_mask[i] = (RR != 0) && (SRCW'(i) > ptr_q);
      end
   endgenerate

   assign req_hi = d_valid & hi_mask;
   assign gnt_hi = req_hi & (-req_hi);
   assign gnt_lo = d_valid & (-d_valid);
   assign gnt    = (|req_hi) ? gnt_hi : gnt_lo;

   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt[k]) begin
            gnt_idx  = SRCW'(k);
            gnt_data = d_ch[k];
         end
      end
   end

   // Nothing is acknowledged while reset is held, so no word is lost mid-handshake.
   assign open    = reset_n && (!y_valid_q || y_ready);
   assign d_ready = open ? gnt : '0;
   assign load    = open && (|d_valid);

   always_comb begin
      y_d       = y_q;
      y_src_d   = y_src_q;
      y_valid_d = y_valid_q;
      ptr_d     = ptr_q;
      if (load) begin
         y_d       = gnt_data;
         y_src_d   = gnt_idx;
         y_valid_d = 1'b1;
         ptr_d     = gnt_idx;
      end else if (y_ready) begin
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         y_q       <= '0;
         y_src_q   <= '0;
         y_valid_q <= 1'b0;
         ptr_q     <= SRCW'(N - 1);
      end else begin
         y_q       <= y_d;
         y_src_q   <= y_src_d;
         y_valid_q <= y_valid_d;
         ptr_q     <= ptr_d;
      end
   end

   assign y       = y_q;
   assign y_src   = y_src_q;
   assign y_valid = y_valid_q;

endmodule
